// File: rtl/chess_clock_pkg.sv
// Shared types and constants for the two-sided chess clock.
// Time is held in whole seconds, capped at 99:59.
package chess_clock_pkg;

  localparam int MAX_SECONDS = 5999;
  localparam int SECS_W      = 13;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    FLAGGED
  } state_t;

  function automatic logic [SECS_W-1:0] sat_add(
    input logic [SECS_W-1:0] a,
    input logic [SECS_W-1:0] b
  );
    logic [SECS_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > (SECS_W+1)'(MAX_SECONDS))
      return SECS_W'(MAX_SECONDS);
    return s[SECS_W-1:0];
  endfunction

endpackage

// File: rtl/chess_clock_if.sv
// Move-controller inputs and display/status outputs of the chess clock.
// The master side drives the controls, the slave side is the clock.
interface chess_clock_if;

  logic        is_white;
  logic        start;
  logic        pause;
  logic [15:0] white_mmss;
  logic [15:0] black_mmss;
  logic        white_flag;
  logic        black_flag;
  logic        running;

  modport master (
    output is_white, start, pause,
    input  white_mmss, black_mmss,
    input  white_flag, black_flag, running
  );

  modport slave (
    input  is_white, start, pause,
    output white_mmss, black_mmss,
    output white_flag, black_flag, running
  );

endinterface

// File: rtl/secs_to_mmss.sv
// Binary seconds (0..5999) to BCD {M tens, M ones, S tens, S ones}.
// Purely combinational.
module secs_to_mmss
  import chess_clock_pkg::*;
(
  input  logic [SECS_W-1:0] i_secs,
  output logic [15:0]       o_mmss
);

  logic [6:0] w_min;
  logic [5:0] w_sec;

  assign w_min = 7'(i_secs / SECS_W'(60));
  assign w_sec = 6'(i_secs % SECS_W'(60));

  assign o_mmss = {
    4'(w_min / 7'd10),
    4'(w_min % 7'd10),
    4'(w_sec / 6'd10),
    4'(w_sec % 6'd10)
  };

endmodule

// File: rtl/chess_clock.sv
// Chess game clock: per-side countdown with Fischer increment and flags.
// The side to move is taken from the registered is_white of the previous cycle.
module chess_clock
  import chess_clock_pkg::*;
#(
  parameter int CLK_HZ            = 100_000_000,
  parameter int START_SECONDS     = 300,
  parameter int INCREMENT_SECONDS = 0
) (
  input  logic          clk,
  input  logic          rst,
  chess_clock_if.slave  bus
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [PW-1:0]     PRESC_TOP = PW'(CLK_HZ - 1);
  localparam logic [SECS_W-1:0] START_V   = SECS_W'(START_SECONDS);
  localparam logic [SECS_W-1:0] INC_V     = SECS_W'(INCREMENT_SECONDS);

  state_t            r_state;
  logic [SECS_W-1:0] r_white_secs;
  logic [SECS_W-1:0] r_black_secs;
  logic              r_white_flag;
  logic              r_black_flag;
  logic              r_running;
  logic              r_prev_white;
  logic [PW-1:0]     r_presc;

  state_t            w_state_n;
  logic [SECS_W-1:0] w_white_n;
  logic [SECS_W-1:0] w_black_n;
  logic              w_wflag_n;
  logic              w_bflag_n;
  logic [PW-1:0]     w_presc_n;
  logic              w_turn;
  logic              w_tick;
  logic [SECS_W-1:0] w_mover;
  logic [SECS_W-1:0] w_dec;
  logic [SECS_W-1:0] w_mover_n;
  logic              w_flag_hit;

  assign w_turn  = bus.is_white != r_prev_white;
  assign w_tick  = (r_state == RUN) && (r_presc == PRESC_TOP);
  assign w_mover = r_prev_white ? r_white_secs : r_black_secs;
  assign w_dec   = w_mover - SECS_W'(1);

  always_comb begin
    w_state_n  = r_state;
    w_white_n  = r_white_secs;
    w_black_n  = r_black_secs;
    w_wflag_n  = r_white_flag;
    w_bflag_n  = r_black_flag;
    w_presc_n  = r_presc;
    w_mover_n  = w_mover;
    w_flag_hit = 1'b0;

    if (!bus.start) begin
      w_state_n = IDLE;
      w_white_n = START_V;
      w_black_n = START_V;
      w_wflag_n = 1'b0;
      w_bflag_n = 1'b0;
      w_presc_n = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_white_n = START_V;
          w_black_n = START_V;
          w_wflag_n = 1'b0;
          w_bflag_n = 1'b0;
          w_presc_n = '0;
          w_state_n = RUN;
        end
        RUN: begin
          w_presc_n = w_tick ? '0 : r_presc + PW'(1);
          // Reaching zero wins over any increment on the same edge
          if (w_tick && w_dec == '0) begin
            w_mover_n  = '0;
            w_flag_hit = 1'b1;
            w_state_n  = FLAGGED;
          end else begin
            if (w_tick)
              w_mover_n = w_dec;
            if (w_turn) begin
              w_mover_n = sat_add(w_mover_n, INC_V);
              w_presc_n = '0;
            end
            if (bus.pause)
              w_state_n = PAUSED;
          end
        end
        PAUSED: begin
          if (w_turn) begin
            w_mover_n = sat_add(w_mover, INC_V);
            w_presc_n = '0;
          end
          if (!bus.pause)
            w_state_n = RUN;
        end
        FLAGGED: begin
        end
        default: w_state_n = IDLE;
      endcase

      if (r_state == RUN || r_state == PAUSED) begin
        if (r_prev_white) begin
          w_white_n = w_mover_n;
          w_wflag_n = r_white_flag | w_flag_hit;
        end else begin
          w_black_n = w_mover_n;
          w_bflag_n = r_black_flag | w_flag_hit;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_white_secs <= START_V;
      r_black_secs <= START_V;
      r_white_flag <= 1'b0;
      r_black_flag <= 1'b0;
      r_running    <= 1'b0;
      r_prev_white <= 1'b1;
      r_presc      <= '0;
    end else begin
      r_state      <= w_state_n;
      r_white_secs <= w_white_n;
      r_black_secs <= w_black_n;
      r_white_flag <= w_wflag_n;
      r_black_flag <= w_bflag_n;
      r_running    <= (w_state_n == RUN);
      r_prev_white <= bus.is_white;
      r_presc      <= w_presc_n;
    end
  end

  assign bus.white_flag = r_white_flag;
  assign bus.black_flag = r_black_flag;
  assign bus.running    = r_running;

  secs_to_mmss u_white_disp (
    .i_secs (r_white_secs),
    .o_mmss (bus.white_mmss)
  );

  secs_to_mmss u_black_disp (
    .i_secs (r_black_secs),
    .o_mmss (bus.black_mmss)
  );

endmodule

// File: doc/chess_clock.md
# chess_clock

Two-sided chess game clock that sits directly downstream of the board/move controller. It watches the controller's registered side-to-move output and counts down the mover's remaining time in whole seconds. It adds a Fischer increment on every completed move and raises a flag when a side runs out. It presents both clocks as BCD mm:ss digits for the seven-segment display driver.

## Interface
- `CLK_HZ`, 100_000_000: clk cycles per second; prescaler terminal count.
- `START_SECONDS`, 300: initial time per side; legal range 1..5999.
- `INCREMENT_SECONDS`, 0: seconds added to the mover after each move; range 0..5999.
- `clk  in  1`: system clock. Everything is on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `is_white  in  1`: side to move, 1 = white. Driven by the move controller's registered output, so it is synchronous to clk.
- `start  in  1`: game-enable level from a switch, already synchronised. 0 forces IDLE.
- `pause  in  1`: hold level, already synchronised.
- `white_mmss  out  16`: white time as BCD {M tens, M ones, S tens, S ones}.
- `black_mmss  out  16`: black time, same format.
- `white_flag  out  1`: white's time has expired. Registered.
- `black_flag  out  1`: black's time has expired. Registered.
- `running  out  1`: high only in the RUN state. Registered.

## Operation
- State
  - `white_secs` and `black_secs`: 13-bit binary counters.
  - `prev_white`: registers `is_white`.
  - `presc`: prescaler of width clog2(CLK_HZ).
  - `state`: one of IDLE, RUN, PAUSED, FLAGGED.
- Reset (asynchronous)
  - Both counters load START_SECONDS.
  - Both flags are 0, `running` is 0, `presc` is 0, `state` is IDLE.
  - `prev_white` is 1.
- Turn change: `turn = is_white != prev_white`. `prev_white` updates every cycle in every state.
- IDLE
  - Counters are held at START_SECONDS, flags are cleared, `presc` is 0.
  - Turn changes are ignored.
  - `start = 1` moves to RUN on the next edge.
- RUN
  - `presc` increments each cycle.
  - When `presc == CLK_HZ-1`, a tick fires and `presc` wraps to 0.
  - On a tick, the side selected by `prev_white` is decremented.
  - A decrement from 1 to 0 sets that side's flag and moves to FLAGGED on the same edge.
- Turn change in RUN or PAUSED
  - INCREMENT_SECONDS is added to the side selected by `prev_white` (the side that just moved).
  - The sum saturates at 5999.
  - `presc` is cleared.
- Tick and turn change on the same cycle
  - The decrement is applied first, then the increment, to the same side. The result is (old − 1 + INC), saturated.
  - If the decrement reaches 0, the flag wins: no increment is added, and the state goes to FLAGGED.
- PAUSED
  - Entered from RUN when `pause = 1`; returns to RUN when `pause = 0`.
  - `presc` holds its value and no ticks occur.
  - Turn changes still apply the increment and clear `presc`.
- FLAGGED
  - Counters and flags are frozen. `pause` and turn changes are ignored.
  - Exit only via `start = 0` or `rst`.
- Priority: `start = 0` (to IDLE, reloading counters) > flag/FLAGGED > `pause` > normal RUN.
- Width rules: counters never underflow, since 0 is reached only through the flag path, and never exceed 5999.

## Timing
- A side loses exactly one second per CLK_HZ RUN cycles, counted from entry to RUN or from the last turn change.
- The first tick comes CLK_HZ cycles after the edge that enters RUN.
- `*_mmss` are combinational from the counters. They reflect a counter update in the same cycle that the counter register changes.
- Flags and `running` are registered. The flag rises on the same edge that the counter becomes 0.
- The move controller updates `is_white` one cycle after it commits a move. The increment is applied on the edge after `is_white` changes, so it lands two cycles after the commit.
- A `pause` pulse of one cycle gives exactly one cycle in PAUSED. `presc` resumes from its held value.

## Structure
- Shared chess package holds:
  - the state enum {IDLE, RUN, PAUSED, FLAGGED};
  - `MAX_SECONDS = 5999`;
  - `SECS_W = 13`.
- One sub-module, `secs_to_mmss`: combinational binary 0..5999 to four BCD digits, using divide/modulo by 60 and by 10. It is instantiated twice.
- The top level holds the FSM, the prescaler, both counters and the turn detector.

## Test plan
All scenarios use CLK_HZ=10, START_SECONDS=3, INCREMENT_SECONDS=2.
- Reset with `start=0`: `white_mmss=16'h0003`, `black_mmss=16'h0003`, flags 0, `running` 0. Holding `start=0` for 100 cycles changes nothing.
- Set `start=1`, `is_white=1`: `running` is 1 one cycle later. White reads 0002 after 10 cycles and 0001 after 20; black stays 0003.
- At white=0002, `presc=5`, toggle `is_white` to 0: white becomes 0004 and `presc` is 0. Black reads 0002 exactly 10 cycles later.
- Black counts 3→0: `black_flag` rises on the edge where black reads 0000, `state` is FLAGGED, `running` is 0. Further toggles and `pause` leave all outputs frozen. `start=0` reloads 0003/0003 and clears the flag.
- `pause=1` for 37 cycles in the middle of a second: no decrement during the pause. The decrement lands exactly 10 RUN cycles after the previous tick. Toggling `is_white` during the pause still adds +2.
- Tick and toggle on the same cycle with white at 0003: white becomes 0004. Separately, with white at 0001: `white_flag` rises and white reads 0000, not 0002. START_SECONDS=5999 with a toggle on the first move: white stays 5999, shown as `16'h9959`.
